// File: rtl/eight_bit_ripple_counter.sv
// 8-bit up-counter built from eight synchronous toggle stages joined by a
// rippling AND carry; every stage shares clk, so the count never ripples in time.

module eight_bit_ripple_counter_tff (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

module eight_bit_ripple_counter (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] Q
);

  // carry[i] is high when every lower bit is 1, so stage i toggles exactly then
  logic [7:0] carry;
  logic [7:0] q_q;

  assign carry[0] = 1'b1;

  for (genvar i = 1; i < 8; i++) begin : g_carry
    assign carry[i] = carry[i-1] & q_q[i-1];
  end

  for (genvar i = 0; i < 8; i++) begin : g_stage
    eight_bit_ripple_counter_tff u_tff (
      .clk   (clk),
      .reset (reset),
      .t     (carry[i]),
      .q     (q_q[i])
    );
  end

  assign Q = q_q;

endmodule

// File: tb/tb_eight_bit_ripple_counter.sv
// Directed checks of the 8-bit counter against hand-computed values and a
// behavioural (prev + 1) mod 256 model, sampled 1 time unit after each edge.

module tb_eight_bit_ripple_counter;

  logic       clk;
  logic       reset;
  logic [7:0] Q;
  logic [7:0] model_q;
  int unsigned n_tests;
  int unsigned n_fail;

  eight_bit_ripple_counter dut (
    .clk   (clk),
    .reset (reset),
    .Q     (Q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
    end
  endtask

  // Advance one edge, update the reference model from the reset level held
  // across that edge, and compare.
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_q = reset ? 8'h00 : model_q + 8'h01;
    check(tag, Q, model_q);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_q = 8'h00;
    reset   = 1'b1;

    // Reset then count: edge at 5 -> 00, reset drops at 8
    tick("reset_edge");
    check("reset_val", Q, 8'h00);
    #2 reset = 1'b0;
    tick("cnt1");  check("cnt1_abs", Q, 8'h01);
    tick("cnt2");  check("cnt2_abs", Q, 8'h02);
    tick("cnt3");  check("cnt3_abs", Q, 8'h03);

    // Fresh reset, then a full run to FF and wrap
    reset = 1'b1;
    tick("rerun_reset");
    reset = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      tick("run");
      if (i == 8'h0F) check("pre_0F", Q, 8'h0F);
      if (i == 8'h10) check("carry_0F_10", Q, 8'h10);
      if (i == 8'h7F) check("pre_7F", Q, 8'h7F);
      if (i == 8'h80) check("carry_7F_80", Q, 8'h80);
    end
    check("full_FF", Q, 8'hFF);
    tick("wrap");  check("wrap_00", Q, 8'h00);
    tick("post_wrap");  check("wrap_01", Q, 8'h01);

    // Mid-count reset at 5A
    while (model_q != 8'h5A) tick("to_5A");
    check("at_5A", Q, 8'h5A);
    reset = 1'b1;
    tick("mid_reset");  check("mid_reset_abs", Q, 8'h00);
    reset = 1'b0;
    tick("mid_release");  check("mid_release_abs", Q, 8'h01);

    // Reset held for ten edges
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick("held");
      check("held_abs", Q, 8'h00);
    end
    reset = 1'b0;
    tick("held_release");  check("held_release_abs", Q, 8'h01);
    tick("held_cnt");  check("held_cnt_abs", Q, 8'h02);

    // Reset pulse entirely between edges has no effect
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    tick("glitch");  check("glitch_abs", Q, 8'h03);
    tick("glitch2");  check("glitch2_abs", Q, 8'h04);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
